discharge_pulse_fsm: RTL and testbench
======================================

# discharge_pulse_fsm

Pulse-sequencing state machine for the EDM discharge channel. It drives the gap MOSFET and publishes the `current_state` code that the breakdown detector qualifies on. It consumes the detector's `is_breakdown` flag and the sampled gap voltage, then times each pulse through four phases: wait for breakdown, discharge on-time, deionisation off-time, and repeat.

## Interface
Clock/reset: one clock; reset is synchronous and active-high.

Parameters:
- `SHORT_THRESHOLD_VOL`, 16'sd3: gap voltage (V) below which the gap counts as shorted.
- `SHORT_THRESHOLD_TIME`, 16'd20: number of consecutive shorted cycles in WAIT_BREAKDOWN that declares a short.

Ports:
- `clk`  in  1  100 MHz system clock.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  machining enable. Level-sensitive.
- `on_time_cycles`  in  16  discharge duration in clk cycles.
- `off_time_cycles`  in  16  deionisation duration in clk cycles.
- `wait_timeout_cycles`  in  16  open-gap timeout in clk cycles. 0 disables the timeout.
- `is_breakdown`  in  1  registered breakdown flag from the detector.
- `sample_voltage`  in  16 signed  gap voltage (V).
- `current_state`  out  8  state code.
- `mosfet_on`  out  1  gate drive.
- `pulse_done`  out  1  1-cycle strobe at the end of a completed discharge.
- `open_timeout`  out  1  1-cycle strobe when the open-gap timeout fires.
- `short_detect`  out  1  1-cycle strobe when a short is declared.
- `pulse_count`, `timeout_count`  out  32 each  statistics counters. Present only when stats are compiled in (see Configuration).

## Operation
- State codes:
  - IDLE = 8'h00
  - WAIT_BREAKDOWN = 8'h01 (the detector is active only in this code)
  - DISCHARGE = 8'h02
  - DEION = 8'h04
- The code is registered and no other values are ever emitted.
- `on_time_cycles`, `off_time_cycles` and `wait_timeout_cycles` are latched on every entry to WAIT_BREAKDOWN. Input changes mid-pulse are ignored.
- A latched on-time or off-time of 0 is treated as 1.
- IDLE → WAIT_BREAKDOWN when `enable` = 1.
- WAIT_BREAKDOWN exits, priority high to low:
  1. `enable` = 0 → DEION.
  2. `is_breakdown` = 1 → DISCHARGE.
  3. Short count reaches `SHORT_THRESHOLD_TIME` → DEION, with a `short_detect` strobe.
  4. Wait counter reaches a nonzero `wait_timeout_cycles` → DEION, with an `open_timeout` strobe.
- Short counter:
  - Increments while `sample_voltage < SHORT_THRESHOLD_VOL`, using a signed compare.
  - Clears on any non-short sample and on leaving WAIT_BREAKDOWN.
- DISCHARGE:
  - Lasts exactly the latched on-time number of cycles, then → DEION with a `pulse_done` strobe.
  - `enable` = 0 aborts immediately → DEION with no `pulse_done`.
- DEION:
  - Lasts exactly the latched off-time number of cycles. This applies after aborts as well.
  - Then → WAIT_BREAKDOWN if `enable` = 1, else → IDLE.
- `mosfet_on` = 1 exactly while `current_state` is WAIT_BREAKDOWN or DISCHARGE. It is registered and aligned with `current_state`.
- Timers are 16-bit and saturate; they never wrap.

## Timing
- Reset values:
  - `current_state` = IDLE.
  - `mosfet_on`, `pulse_done`, `open_timeout`, `short_detect` = 0.
  - All counters, timers and latched parameters = 0.
- Reset mid-pulse drops `mosfet_on` on the next edge.
- The IDLE → WAIT transition takes effect 1 cycle after `enable` rises.
- `is_breakdown` sampled high at edge N makes `current_state` = DISCHARGE after edge N.
- The detector needs at least 1 cycle in WAIT before it can assert, so the minimum WAIT dwell is 2 cycles.
- Each strobe is high for the first cycle of the following DEION state.
- `enable` dropping at edge N puts the block in DEION with `mosfet_on` = 0 after edge N.

## Configuration
- Macro `DISCHARGE_PULSE_STATS_EN`.
- Defined:
  - `pulse_count` increments on each `pulse_done`.
  - `timeout_count` increments on each `open_timeout`.
  - Both are 32-bit, wrap naturally, and clear only on reset.
- Undefined: both ports and their counters are absent.

## Structure
- Shared package `edm_pkg`:
  - State code localparams: S_IDLE, S_WAIT_BREAKDOWN, S_DISCHARGE, S_DEION.
  - Timer width constant (16).
- The detector uses the same package.
- One natural sub-module, `discharge_timer`: a loadable, saturating 16-bit count-up timer with `clear` and `expired` (count ≥ limit−1). It is instanced once for the phase timer and once for the wait-timeout timer.

## Test plan
- Normal pulse:
  - Stimulus: on = 5, off = 3, `enable` = 1, `is_breakdown` pulsed 4 cycles after WAIT entry.
  - Response: DISCHARGE lasts exactly 5 cycles, `pulse_done` is high for 1 cycle, DEION lasts 3 cycles, then WAIT; `pulse_count` = 1.
- Open-gap timeout:
  - Stimulus: timeout = 10, no breakdown.
  - Response: after 10 WAIT cycles, `open_timeout` strobes and the block enters DEION with `mosfet_on` = 0; `timeout_count` = 1.
- Short:
  - Stimulus: `sample_voltage` = 0 for 20 cycles in WAIT.
  - Response: `short_detect` strobes and the block enters DEION.
  - Stimulus: a single sample of 5 V at cycle 19.
  - Response: the short counter restarts and there is no strobe.
- Abort:
  - Stimulus: `enable` → 0 at cycle 2 of DISCHARGE.
  - Response: next cycle DEION, `mosfet_on` = 0, no `pulse_done`; IDLE after the off-time.
- Zero on-time:
  - Stimulus: on = 0, a breakdown occurs.
  - Response: DISCHARGE lasts 1 cycle.
- Reset mid-DISCHARGE:
  - Stimulus: `rst` = 1 during DISCHARGE.
  - Response: next edge gives IDLE with all outputs at 0.
- Simultaneous events:
  - Stimulus: timeout expiry and `is_breakdown` on the same edge.
  - Response: DISCHARGE wins and `open_timeout` stays low.

Source files
------------

// File: rtl/edm_pkg.sv
// Shared EDM definitions: state codes published to the breakdown detector, timer width, helpers.
package edm_pkg;

  localparam int TIMER_W = 16;

  localparam logic [7:0] S_IDLE           = 8'h00;
  localparam logic [7:0] S_WAIT_BREAKDOWN = 8'h01;
  localparam logic [7:0] S_DISCHARGE      = 8'h02;
  localparam logic [7:0] S_DEION          = 8'h04;

  typedef enum logic [7:0] {
    ST_IDLE      = S_IDLE,
    ST_WAIT      = S_WAIT_BREAKDOWN,
    ST_DISCHARGE = S_DISCHARGE,
    ST_DEION     = S_DEION
  } state_t;

  // A zero-length phase still has to occupy one cycle.
  function automatic logic [TIMER_W-1:0] at_least_one(input logic [TIMER_W-1:0] v);
    return (v == '0) ? TIMER_W'(1) : v;
  endfunction

endpackage

// File: rtl/discharge_timer.sv
// Loadable saturating count-up timer; expired when count >= limit-1.
// Latency: expired is combinational from the registered count; no backpressure.
// Load wins over clear, clear wins over run; the count holds at all-ones.
module discharge_timer
  import edm_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] limit,
  input  logic               clear,
  input  logic               run,
  output logic               expired
);

  logic [TIMER_W-1:0] count;
  logic [TIMER_W-1:0] limit_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      limit_q <= '0;
    end else if (load) begin
      count   <= '0;
      limit_q <= limit;
    end else if (clear) begin
      count <= '0;
    end else if (run && (count != '1)) begin
      count <= count + TIMER_W'(1);
    end
  end

  // Extra bit keeps limit 0 from underflowing; it reads as already expired.
  assign expired = ({1'b0, count} + (TIMER_W+1)'(1)) >= {1'b0, limit_q};

endmodule

// File: rtl/discharge_pulse_fsm.sv
// EDM pulse sequencer: WAIT_BREAKDOWN -> DISCHARGE -> DEION; optional stats via DISCHARGE_PULSE_STATS_EN.
// Latency: state, mosfet_on and strobes are registered, one cycle after the deciding edge.
// No backpressure: strobes are single-cycle and must be consumed when seen.
module discharge_pulse_fsm
  import edm_pkg::*;
#(
  parameter logic signed [15:0] SHORT_THRESHOLD_VOL  = 16'sd3,
  parameter logic        [15:0] SHORT_THRESHOLD_TIME = 16'd20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [15:0]        on_time_cycles,
  input  logic [15:0]        off_time_cycles,
  input  logic [15:0]        wait_timeout_cycles,
  input  logic               is_breakdown,
  input  logic signed [15:0] sample_voltage,
  output logic [7:0]         current_state,
  output logic               mosfet_on,
  output logic               pulse_done,
  output logic               open_timeout,
  output logic               short_detect
`ifdef DISCHARGE_PULSE_STATS_EN
  ,
  output logic [31:0]        pulse_count,
  output logic [31:0]        timeout_count
`endif
);

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] on_lat, off_lat, wto_lat, short_cnt;
  logic               pulse_done_d, open_timeout_d, short_detect_d;
  logic               enter_wait, short_now, short_hit;
  logic               phase_load, phase_clear, phase_run, phase_expired;
  logic [TIMER_W-1:0] phase_limit;
  logic               wait_clear, wait_run, wait_expired;

  assign current_state = state_q;
  assign short_now     = sample_voltage < SHORT_THRESHOLD_VOL;
  assign short_hit     = short_now &&
                         (({1'b0, short_cnt} + 17'd1) >= {1'b0, SHORT_THRESHOLD_TIME});

  always_comb begin
    state_d        = state_q;
    pulse_done_d   = 1'b0;
    open_timeout_d = 1'b0;
    short_detect_d = 1'b0;
    unique case (state_q)
      ST_IDLE: if (enable) state_d = ST_WAIT;
      ST_WAIT: begin
        if (!enable) begin
          state_d = ST_DEION;
        end else if (is_breakdown) begin
          state_d = ST_DISCHARGE;
        end else if (short_hit) begin
          state_d        = ST_DEION;
          short_detect_d = 1'b1;
        end else if ((wto_lat != '0) && wait_expired) begin
          state_d        = ST_DEION;
          open_timeout_d = 1'b1;
        end
      end
      ST_DISCHARGE: begin
        if (!enable) begin
          state_d = ST_DEION;
        end else if (phase_expired) begin
          state_d      = ST_DEION;
          pulse_done_d = 1'b1;
        end
      end
      ST_DEION: if (phase_expired) state_d = enable ? ST_WAIT : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    enter_wait  = (state_d == ST_WAIT) && (state_q != ST_WAIT);
    phase_load  = (state_d != state_q) &&
                  ((state_d == ST_DISCHARGE) || (state_d == ST_DEION));
    phase_limit = (state_d == ST_DISCHARGE) ? at_least_one(on_lat) : at_least_one(off_lat);
    phase_clear = (state_q == ST_IDLE);
    phase_run   = (state_q == ST_DISCHARGE) || (state_q == ST_DEION);
    wait_clear  = (state_d != ST_WAIT);
    wait_run    = (state_q == ST_WAIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mosfet_on    <= 1'b0;
      pulse_done   <= 1'b0;
      open_timeout <= 1'b0;
      short_detect <= 1'b0;
      on_lat       <= '0;
      off_lat      <= '0;
      wto_lat      <= '0;
      short_cnt    <= '0;
    end else begin
      state_q      <= state_d;
      mosfet_on    <= (state_d == ST_WAIT) || (state_d == ST_DISCHARGE);
      pulse_done   <= pulse_done_d;
      open_timeout <= open_timeout_d;
      short_detect <= short_detect_d;
      if (enter_wait) begin
        on_lat  <= on_time_cycles;
        off_lat <= off_time_cycles;
        wto_lat <= wait_timeout_cycles;
      end
      if ((state_q == ST_WAIT) && (state_d == ST_WAIT) && short_now)
        short_cnt <= (short_cnt == '1) ? short_cnt : short_cnt + TIMER_W'(1);
      else
        short_cnt <= '0;
    end
  end

  discharge_timer u_phase_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (phase_load),
    .limit   (phase_limit),
    .clear   (phase_clear),
    .run     (phase_run),
    .expired (phase_expired)
  );

  // Loaded straight from the input on WAIT entry, the same edge wto_lat latches.
  discharge_timer u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (enter_wait),
    .limit   (wait_timeout_cycles),
    .clear   (wait_clear),
    .run     (wait_run),
    .expired (wait_expired)
  );

`ifdef DISCHARGE_PULSE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_count   <= '0;
      timeout_count <= '0;
    end else begin
      if (pulse_done_d)   pulse_count   <= pulse_count + 32'd1;
      if (open_timeout_d) timeout_count <= timeout_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_discharge_pulse_fsm.sv
// Randomized and directed bench for discharge_pulse_fsm against a phase/dwell reference model.
module tb_discharge_pulse_fsm;

  logic               clk = 1'b0;
  logic               d_rst = 1'b1;
  logic               d_en = 1'b0;
  logic [15:0]        d_on = '0, d_off = '0, d_to = '0;
  logic               d_brk = 1'b0;
  logic signed [15:0] d_v = 16'sd50;
  logic [7:0]         current_state;
  logic               mosfet_on, pulse_done, open_timeout, short_detect;
`ifdef DISCHARGE_PULSE_STATS_EN
  logic [31:0]        pulse_count, timeout_count;
`endif

  always #5 clk = ~clk;

  discharge_pulse_fsm dut (
    .clk                 (clk),
    .rst                 (d_rst),
    .enable              (d_en),
    .on_time_cycles      (d_on),
    .off_time_cycles     (d_off),
    .wait_timeout_cycles (d_to),
    .is_breakdown        (d_brk),
    .sample_voltage      (d_v),
    .current_state       (current_state),
    .mosfet_on           (mosfet_on),
    .pulse_done          (pulse_done),
    .open_timeout        (open_timeout),
    .short_detect        (short_detect)
`ifdef DISCHARGE_PULSE_STATS_EN
    ,
    .pulse_count         (pulse_count),
    .timeout_count       (timeout_count)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: phase 0 idle, 1 waiting, 2 discharging, 3 deionising; dwell = cycles finished in phase.
  int          m_phase = 0, m_dwell = 0, m_short = 0, m_on = 0, m_off = 0, m_to = 0;
  bit          e_pd = 0, e_to = 0, e_sd = 0;
  logic [31:0] e_pc = '0, e_tc = '0;

  function automatic int max1(input int x);
    return (x == 0) ? 1 : x;
  endfunction

  function automatic logic [7:0] code_of(input int ph);
    case (ph)
      1:       return 8'h01;
      2:       return 8'h02;
      3:       return 8'h04;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_step();
    int nxt, dw, sc;
    bit pd, to, sd;
    if (d_rst) begin
      m_phase = 0; m_dwell = 0; m_short = 0; m_on = 0; m_off = 0; m_to = 0;
      e_pd = 0; e_to = 0; e_sd = 0; e_pc = '0; e_tc = '0;
      return;
    end
    nxt = m_phase; dw = m_dwell + 1; sc = 0; pd = 0; to = 0; sd = 0;
    case (m_phase)
      0: if (d_en) nxt = 1;
      1: begin
        sc = (d_v < 16'sd3) ? m_short + 1 : 0;
        if (!d_en)                     nxt = 3;
        else if (d_brk)                nxt = 2;
        else if (sc >= 20)             begin nxt = 3; sd = 1; end
        else if (m_to != 0 && dw >= m_to) begin nxt = 3; to = 1; end
      end
      2: begin
        if (!d_en)                   nxt = 3;
        else if (dw >= max1(m_on))   begin nxt = 3; pd = 1; end
      end
      default: if (dw >= max1(m_off)) nxt = d_en ? 1 : 0;
    endcase
    if (nxt == 1 && m_phase != 1) begin
      m_on = int'(d_on); m_off = int'(d_off); m_to = int'(d_to);
    end
    m_short = (m_phase == 1 && nxt == 1) ? sc : 0;
    m_dwell = (nxt != m_phase) ? 0 : dw;
    m_phase = nxt;
    e_pd = pd; e_to = to; e_sd = sd;
    if (pd) e_pc = e_pc + 32'd1;
    if (to) e_tc = e_tc + 32'd1;
  endtask

  // Apply the current d_* inputs for one cycle, then compare at the falling edge.
  task automatic cyc();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check("state", 32'(current_state), 32'(code_of(m_phase)));
    check("mosfet_on", 32'(mosfet_on), 32'(m_phase == 1 || m_phase == 2));
    check("pulse_done", 32'(pulse_done), 32'(e_pd));
    check("open_timeout", 32'(open_timeout), 32'(e_to));
    check("short_detect", 32'(short_detect), 32'(e_sd));
`ifdef DISCHARGE_PULSE_STATS_EN
    check("pulse_count", pulse_count, e_pc);
    check("timeout_count", timeout_count, e_tc);
`endif
  endtask

  task automatic run_while(input logic [7:0] code, output int n);
    n = 0;
    while (current_state == code && n < 300) begin
      n++;
      cyc();
    end
  endtask

  task automatic do_reset(input logic [15:0] on, input logic [15:0] off, input logic [15:0] to);
    d_rst = 1'b1; d_en = 1'b0; d_brk = 1'b0; d_v = 16'sd50;
    d_on = on; d_off = off; d_to = to;
    cyc();
    d_rst = 1'b0;
  endtask

  initial begin
    int n;
    int t;
    int brk_pct, en_pct;
    bit short_mode;

    // Reset state
    do_reset(16'd5, 16'd3, 16'd0);
    check("reset_state", 32'(current_state), 32'h00);

    // Normal pulse: breakdown on the 4th WAIT cycle
    d_en = 1'b1;
    cyc();
    repeat (3) cyc();
    d_brk = 1'b1; cyc(); d_brk = 1'b0;
    run_while(8'h02, n);
    check("on_len", 32'(n), 32'd5);
    check("pd_strobe", 32'(pulse_done), 32'd1);
    run_while(8'h04, n);
    check("off_len", 32'(n), 32'd3);
    check("back_to_wait", 32'(current_state), 32'h01);
`ifdef DISCHARGE_PULSE_STATS_EN
    check("pulse_count_1", pulse_count, 32'd1);
`endif

    // Open-gap timeout of 10
    do_reset(16'd5, 16'd3, 16'd10);
    d_en = 1'b1; cyc();
    run_while(8'h01, n);
    check("wait_len_timeout", 32'(n), 32'd10);
    check("timeout_strobe", 32'(open_timeout), 32'd1);
    check("timeout_mosfet", 32'(mosfet_on), 32'd0);
`ifdef DISCHARGE_PULSE_STATS_EN
    check("timeout_count_1", timeout_count, 32'd1);
`endif

    // Sustained short
    do_reset(16'd5, 16'd3, 16'd0);
    d_en = 1'b1; cyc();
    d_v = 16'sd0;
    run_while(8'h01, n);
    check("wait_len_short", 32'(n), 32'd20);
    check("short_strobe", 32'(short_detect), 32'd1);

    // One healthy sample at WAIT cycle 19 restarts the short count
    do_reset(16'd5, 16'd3, 16'd0);
    d_en = 1'b1; cyc();
    d_v = 16'sd0; repeat (18) cyc();
    d_v = 16'sd5; cyc();
    d_v = 16'sd0; repeat (19) cyc();
    check("short_restart", 32'(current_state), 32'h01);
    cyc();
    check("short_late", 32'(short_detect), 32'd1);

    // Abort on cycle 2 of DISCHARGE
    do_reset(16'd5, 16'd3, 16'd0);
    d_en = 1'b1; cyc(); cyc();
    d_brk = 1'b1; cyc(); d_brk = 1'b0;
    cyc();
    d_en = 1'b0; cyc();
    check("abort_state", 32'(current_state), 32'h04);
    check("abort_no_pd", 32'(pulse_done), 32'd0);
    run_while(8'h04, n);
    check("abort_off_len", 32'(n), 32'd3);
    check("abort_idle", 32'(current_state), 32'h00);

    // Zero on-time behaves as one cycle
    do_reset(16'd0, 16'd2, 16'd0);
    d_en = 1'b1; cyc();
    d_brk = 1'b1; cyc(); d_brk = 1'b0;
    run_while(8'h02, n);
    check("zero_on_len", 32'(n), 32'd1);

    // Reset in the middle of DISCHARGE
    do_reset(16'd5, 16'd3, 16'd0);
    d_en = 1'b1; cyc();
    d_brk = 1'b1; cyc(); d_brk = 1'b0;
    cyc();
    d_rst = 1'b1; cyc(); d_rst = 1'b0;
    check("rst_mid_state", 32'(current_state), 32'h00);
    check("rst_mid_mosfet", 32'(mosfet_on), 32'd0);

    // Timeout expiry and breakdown together: breakdown wins
    do_reset(16'd5, 16'd3, 16'd3);
    d_en = 1'b1; cyc();
    cyc(); cyc();
    d_brk = 1'b1; cyc(); d_brk = 1'b0;
    check("simul_state", 32'(current_state), 32'h02);
    check("simul_no_timeout", 32'(open_timeout), 32'd0);

    // Randomized segments
    do_reset(16'd1, 16'd1, 16'd0);
    for (int seg = 0; seg < 50; seg++) begin
      brk_pct    = ($urandom_range(0, 2) == 0) ? 0 : (($urandom_range(0, 1) == 0) ? 3 : 15);
      en_pct     = ($urandom_range(0, 1) == 0) ? 100 : 97;
      short_mode = ($urandom_range(0, 1) == 0);
      for (int c = 0; c < 60; c++) begin
        d_rst = ($urandom_range(0, 399) == 0);
        d_en  = ($urandom_range(0, 99) < en_pct);
        d_on  = 16'($urandom_range(0, 6));
        d_off = 16'($urandom_range(0, 5));
        d_to  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
        d_brk = ($urandom_range(0, 99) < brk_pct);
        if (short_mode)
          t = ($urandom_range(0, 19) == 0) ? 5 : $urandom_range(0, 7) - 5;
        else
          t = $urandom_range(0, 220) - 20;
        d_v = 16'(t);
        cyc();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
